regfile_2r1w: RTL

//   Integer register file for the pipelined RISC core: two asynchronous read ports for decode, one synchronous write port for writeback.

---
 rtl/regfile_2r1w.sv | 59 +++++
 1 files changed

// File: rtl/regfile_2r1w.sv
// 32 x DATA_W integer register file: two combinational read ports, one clocked write port
// with write-through bypass so writeback data is visible to decode in the same cycle.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]             wr_onehot;
  logic [DEPTH-1:0][DATA_W-1:0] regs_q;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      // wr_en gates the compare so an X address on an idle cycle cannot enable a write.
      assign wr_onehot[gi] = wr_en && (wr_addr == ADDR_W'(gi));

      if (gi == 0) begin : g_zero
        assign regs_q[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] data_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            data_reg <= '0;
          end else if (wr_onehot[gi]) begin
            data_reg <= wr_data;
          end
        end

        assign regs_q[gi] = data_reg;
      end
    end
  endgenerate

  logic wr_live;
  logic bypass1;
  logic bypass2;

  // Bypass is suppressed in reset so the read ports stay at zero while rst_n is low.
  assign wr_live  = rst_n && wr_en && (wr_addr != '0);
  assign bypass1  = wr_live && (wr_addr == rd_addr1);
  assign bypass2  = wr_live && (wr_addr == rd_addr2);

  assign rd_data1 = bypass1 ? wr_data : regs_q[rd_addr1];
  assign rd_data2 = bypass2 ? wr_data : regs_q[rd_addr2];

endmodule
